branch_rs_multi: RTL

Multi-entry reservation station for conditional branches, the parametrised successor to the single-slot branch RS. It accepts branch instructions from the instruction CDB when the FU id matches, and holds up to DEPTH branches while it snoops the data CDB for outstanding operands. It evaluates BGE/BLT/BEQ/BNE in signed or unsigned mode and returns the taken flag, tagged with its RB index, through a valid/ack result port. It sits between the issue stage and the reorder buffer.

---
 rtl/branch_rs_multi_pkg.sv | 35 +++
 rtl/branch_rs_multi_entry.sv | 97 +++++++++
 rtl/branch_rs_multi.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/branch_rs_multi_pkg.sv
// Shared widths, branch op encodings and CDB access helper for the branch reservation station.
package branch_rs_multi_pkg;

    localparam int BR_WORD_SIZE = 32;
    localparam int BR_RB_INDEX  = 4;
    localparam int BR_RB_SIZE   = 2 ** BR_RB_INDEX;
    localparam int BR_FU_INDEX  = 4;

    localparam logic [BR_RB_INDEX-1:0] BR_NULL_TAG = '1;

    typedef enum logic [1:0] {
        BR_BGE = 2'd0,
        BR_BLT = 2'd1,
        BR_BEQ = 2'd2,
        BR_BNE = 2'd3
    } br_op_e;

    typedef struct packed {
        logic                    valid;
        logic [BR_WORD_SIZE-1:0] data;
    } cdb_slot_t;

    // Data CDB lane for one RB tag: its valid bit and word.
    function automatic cdb_slot_t cdb_read(
        input logic [BR_WORD_SIZE*BR_RB_SIZE-1:0] data,
        input logic [BR_RB_SIZE-1:0]              valid,
        input logic [BR_RB_INDEX-1:0]             tag
    );
        cdb_slot_t slot;
        slot.valid = valid[tag];
        slot.data  = data[tag*BR_WORD_SIZE +: BR_WORD_SIZE];
        return slot;
    endfunction

endpackage

// File: rtl/branch_rs_multi_entry.sv
// One reservation-station slot: captures operands at issue (with CDB bypass) and snoops the CDB.
module branch_rs_entry
    import branch_rs_multi_pkg::*;
#(
    parameter int WORD_SIZE = BR_WORD_SIZE,
    parameter int RB_INDEX  = BR_RB_INDEX,
    parameter int RANK_W    = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               alloc,
    input  logic                               dispatch,
    input  logic                               age_dec,
    input  logic [RANK_W-1:0]                  alloc_rank,
    input  br_op_e                             alloc_op,
    input  logic [RB_INDEX-1:0]                alloc_tag,
    input  logic [WORD_SIZE-1:0]               alloc_vj,
    input  logic [WORD_SIZE-1:0]               alloc_vk,
    input  logic [RB_INDEX-1:0]                alloc_qj,
    input  logic [RB_INDEX-1:0]                alloc_qk,
    input  logic                               alloc_rj,
    input  logic                               alloc_rk,
    input  logic [WORD_SIZE*(2**RB_INDEX)-1:0] cdb_data,
    input  logic [(2**RB_INDEX)-1:0]           cdb_valid,
    output logic                               busy,
    output logic                               ready,
    output br_op_e                             op,
    output logic [RB_INDEX-1:0]                tag,
    output logic [WORD_SIZE-1:0]               vj,
    output logic [WORD_SIZE-1:0]               vk,
    output logic [RANK_W-1:0]                  rank
);

    logic [WORD_SIZE-1:0] in_v [2];
    logic [RB_INDEX-1:0]  in_q [2];
    logic [1:0]           in_r;
    logic [WORD_SIZE-1:0] v [2];
    logic [RB_INDEX-1:0]  q [2];
    logic [1:0]           rdy;
    cdb_slot_t            hit_new [2];
    cdb_slot_t            hit_held [2];

    assign in_v[0] = alloc_vj;
    assign in_v[1] = alloc_vk;
    assign in_q[0] = alloc_qj;
    assign in_q[1] = alloc_qk;
    assign in_r    = {alloc_rk, alloc_rj};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            hit_new[i]  = cdb_read(cdb_data, cdb_valid, in_q[i]);
            hit_held[i] = cdb_read(cdb_data, cdb_valid, q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            rdy  <= '0;
            rank <= '0;
        end else if (alloc) begin
            busy <= 1'b1;
            rank <= alloc_rank;
            for (int i = 0; i < 2; i++)
                rdy[i] <= in_r[i] | hit_new[i].valid;
        end else begin
            if (dispatch)
                busy <= 1'b0;
            if (age_dec)
                rank <= rank - RANK_W'(1);
            for (int i = 0; i < 2; i++)
                if (busy && !rdy[i] && hit_held[i].valid)
                    rdy[i] <= 1'b1;
        end
    end

    // Payload registers carry no reset; busy/rdy qualify them.
    always_ff @(posedge clk) begin
        if (alloc) begin
            op  <= alloc_op;
            tag <= alloc_tag;
            for (int i = 0; i < 2; i++) begin
                v[i] <= in_r[i] ? in_v[i] : hit_new[i].data;
                q[i] <= in_q[i];
            end
        end else begin
            for (int i = 0; i < 2; i++)
                if (!rdy[i] && hit_held[i].valid)
                    v[i] <= hit_held[i].data;
        end
    end

    assign ready = busy & (&rdy);
    assign vj    = v[0];
    assign vk    = v[1];

endmodule

// File: rtl/branch_rs_multi.sv
// Multi-entry branch reservation station: allocation, oldest-ready dispatch, compare and result register.
module branch_rs_multi
    import branch_rs_multi_pkg::*;
#(
    parameter int WORD_SIZE  = BR_WORD_SIZE,
    parameter int RB_INDEX   = BR_RB_INDEX,
    parameter int FU_INDEX   = BR_FU_INDEX,
    parameter int FU_ID      = 0,
    parameter int DEPTH      = 4,
    parameter int SIGNED_CMP = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [FU_INDEX-1:0]             issue_fu,
    input  logic [RB_INDEX-1:0]             issue_rb_index,
    input  logic [1:0]                      issue_op,
    input  logic [WORD_SIZE-1:0]            issue_vj,
    input  logic [WORD_SIZE-1:0]            issue_vk,
    input  logic [RB_INDEX-1:0]             issue_qj,
    input  logic [RB_INDEX-1:0]             issue_qk,
    input  logic                            issue_rj,
    input  logic                            issue_rk,
    output logic                            full,
    input  logic [WORD_SIZE*(2**RB_INDEX)-1:0] CDB_data_data,
    input  logic [(2**RB_INDEX)-1:0]        CDB_data_valid,
    output logic                            out_valid,
    output logic [WORD_SIZE-1:0]            out_data,
    output logic [RB_INDEX-1:0]             out_rb_index,
    input  logic                            out_ack
);

    localparam int RANK_W = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0]     e_busy, e_ready;
    br_op_e               e_op   [DEPTH];
    logic [RB_INDEX-1:0]  e_tag  [DEPTH];
    logic [WORD_SIZE-1:0] e_vj   [DEPTH];
    logic [WORD_SIZE-1:0] e_vk   [DEPTH];
    logic [RANK_W-1:0]    e_rank [DEPTH];

    logic [CNT_W-1:0]  count;
    logic              accept, dispatch, alloc_found, sel_found, taken;
    logic [RANK_W-1:0] alloc_idx, alloc_rank, sel_idx, sel_rank;

    function automatic logic br_taken(input br_op_e op, input logic [WORD_SIZE-1:0] a,
                                      input logic [WORD_SIZE-1:0] b);
        logic signed [WORD_SIZE:0] sa, sb;
        logic lt, res;
        sa  = (SIGNED_CMP != 0) ? {a[WORD_SIZE-1], a} : {1'b0, a};
        sb  = (SIGNED_CMP != 0) ? {b[WORD_SIZE-1], b} : {1'b0, b};
        lt  = sa < sb;
        res = 1'b0;
        case (op)
            BR_BGE: res = !lt;
            BR_BLT: res = lt;
            BR_BEQ: res = (a == b);
            BR_BNE: res = (a != b);
        endcase
        return res;
    endfunction

    assign full   = (count == CNT_W'(DEPTH));
    assign accept = (issue_fu == FU_INDEX'(FU_ID)) && !full;

    // Lowest free slot for allocation; oldest (smallest rank) ready slot for dispatch.
    always_comb begin
        alloc_found = 1'b0;
        alloc_idx   = '0;
        sel_found   = 1'b0;
        sel_idx     = '0;
        sel_rank    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!e_busy[i] && !alloc_found) begin
                alloc_found = 1'b1;
                alloc_idx   = RANK_W'(i);
            end
            if (e_ready[i] && (!sel_found || e_rank[i] < sel_rank)) begin
                sel_found = 1'b1;
                sel_idx   = RANK_W'(i);
                sel_rank  = e_rank[i];
            end
        end
    end

    assign dispatch   = sel_found && (!out_valid || out_ack);
    assign alloc_rank = RANK_W'(count - CNT_W'(dispatch));
    assign taken      = br_taken(e_op[sel_idx], e_vj[sel_idx], e_vk[sel_idx]);

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        branch_rs_entry #(
            .WORD_SIZE (WORD_SIZE),
            .RB_INDEX  (RB_INDEX),
            .RANK_W    (RANK_W)
        ) u_entry (
            .clk        (clk),
            .reset      (reset),
            .alloc      (accept && alloc_found && alloc_idx == RANK_W'(g)),
            .dispatch   (dispatch && sel_idx == RANK_W'(g)),
            .age_dec    (dispatch && e_busy[g] && e_rank[g] > sel_rank),
            .alloc_rank (alloc_rank),
            .alloc_op   (br_op_e'(issue_op)),
            .alloc_tag  (issue_rb_index),
            .alloc_vj   (issue_vj),
            .alloc_vk   (issue_vk),
            .alloc_qj   (issue_qj),
            .alloc_qk   (issue_qk),
            .alloc_rj   (issue_rj),
            .alloc_rk   (issue_rk),
            .cdb_data   (CDB_data_data),
            .cdb_valid  (CDB_data_valid),
            .busy       (e_busy[g]),
            .ready      (e_ready[g]),
            .op         (e_op[g]),
            .tag        (e_tag[g]),
            .vj         (e_vj[g]),
            .vk         (e_vk[g]),
            .rank       (e_rank[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (accept && !dispatch) begin
            count <= count + CNT_W'(1);
        end else if (!accept && dispatch) begin
            count <= count - CNT_W'(1);
        end
    end

    // Result register stage: loads on dispatch, clears on a bare ack, holds while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_rb_index <= BR_NULL_TAG;
        end else if (dispatch) begin
            out_valid    <= 1'b1;
            out_data     <= WORD_SIZE'(taken);
            out_rb_index <= e_tag[sel_idx];
        end else if (out_ack) begin
            out_valid    <= 1'b0;
            out_rb_index <= BR_NULL_TAG;
        end
    end

endmodule
